// File: rtl/twiddle_gen_if.sv
// Handshake bundle between twiddle_gen and its consumer.
// Defining TW_INV_EN adds the inv request bit.
interface twiddle_gen_if #(
  parameter int LOG2N = 6
);
  logic             start;
  logic             tw_ready;
  logic [31:0]      tw_out;
  logic             tw_valid;
  logic [LOG2N-1:0] tw_stage;
  logic             tw_last;
  logic             busy;
  logic             done;
`ifdef TW_INV_EN
  logic             inv;

  modport master (
    input  start, tw_ready, inv,
    output tw_out, tw_valid, tw_stage, tw_last, busy, done
  );
  modport slave (
    output start, tw_ready, inv,
    input  tw_out, tw_valid, tw_stage, tw_last, busy, done
  );
`else
  modport master (
    input  start, tw_ready,
    output tw_out, tw_valid, tw_stage, tw_last, busy, done
  );
  modport slave (
    output start, tw_ready,
    input  tw_out, tw_valid, tw_stage, tw_last, busy, done
  );
`endif
endinterface

// File: rtl/twiddle_gen.sv
// Radix-2 DIT twiddle sequencer: quarter-wave cosine ROM, symmetry logic, 3-stage stallable pipeline.
// Defining TW_INV_EN adds the inv input, which selects conjugate twiddles for an IFFT pass.
module twiddle_gen #(
  parameter int    N        = 64,
  parameter int    LOG2N    = 6,
  parameter string ROM_FILE = "cos_q15.mem"
) (
  input  logic          clk,
  input  logic          rst,
  twiddle_gen_if.master bus
);
  localparam int Q  = N / 4;
  localparam int AW = LOG2N - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [LOG2N-1:0] s_cnt;
  logic [AW-1:0]    b_cnt;
  logic             en, issue, last_issue, last_accept, done_nx, inv_q;
  logic [AW-1:0]    mask, k, re_addr, im_addr;
  logic             lo_half;

  logic             p1_valid, p1_last, p1_re_neg;
  logic [LOG2N-1:0] p1_stage;
  logic [15:0]      p1_re, p1_im;

  // round(32767*cos(2*pi*idx/N)) via Taylor series, evaluated at elaboration
  function automatic logic [15:0] cos_q15(input int unsigned idx);
    real x, term, sum;
    x    = 2.0 * 3.14159265358979323846 * real'(idx) / real'(N);
    term = 1.0;
    sum  = 1.0;
    for (int unsigned n = 1; n <= 14; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return 16'($rtoi(32767.0 * sum + 0.5));
  endfunction

  // Same contents as the ROM_FILE image; an empty name leaves the table blank, as a missing image would.
  logic [15:0] rom_tbl [Q+1];
  for (genvar i = 0; i <= Q; i++) begin : g_rom
    localparam logic [15:0] ENTRY = cos_q15(i);
    assign rom_tbl[i] = (ROM_FILE != "") ? ENTRY : '0;
  end

  assign en          = !bus.tw_valid || bus.tw_ready;
  assign issue       = (state == RUN) && en;
  assign last_issue  = issue && (&b_cnt) && (s_cnt == LOG2N'(LOG2N - 1));
  assign last_accept = bus.tw_valid && bus.tw_ready && bus.tw_last;
  assign bus.busy    = (state != IDLE);

  // P0: exponent and symmetry-folded ROM addresses
  always_comb begin
    mask    = ~({AW{1'b1}} << s_cnt);
    k       = (b_cnt & mask) << (LOG2N'(AW) - s_cnt);
    lo_half = (k <= AW'(Q));
    re_addr = lo_half ? k : AW'(N / 2 - int'(k));
    im_addr = lo_half ? AW'(Q) - k : k - AW'(Q);
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      DRAIN:   if (last_accept) begin
                 state_nx = IDLE;
                 done_nx  = 1'b1;
               end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_cnt    <= '0;
      b_cnt    <= '0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.done <= done_nx;
      if (issue) begin
        b_cnt <= b_cnt + 1'b1;
        if (&b_cnt) s_cnt <= (s_cnt == LOG2N'(LOG2N - 1)) ? '0 : s_cnt + 1'b1;
      end
    end
  end

`ifdef TW_INV_EN
  always_ff @(posedge clk) begin
    if (rst) inv_q <= 1'b0;
    else if (state == IDLE && bus.start) inv_q <= bus.inv;
  end
`else
  assign inv_q = 1'b0;
`endif

  // P1: synchronous ROM read; P2: sign application into the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid     <= 1'b0;
      p1_last      <= 1'b0;
      p1_re_neg    <= 1'b0;
      p1_stage     <= '0;
      p1_re        <= '0;
      p1_im        <= '0;
      bus.tw_valid <= 1'b0;
      bus.tw_out   <= '0;
      bus.tw_stage <= '0;
      bus.tw_last  <= 1'b0;
    end else if (en) begin
      p1_valid     <= (state == RUN);
      p1_last      <= last_issue;
      p1_re_neg    <= !lo_half;
      p1_stage     <= s_cnt;
      p1_re        <= rom_tbl[re_addr];
      p1_im        <= rom_tbl[im_addr];
      bus.tw_valid <= p1_valid;
      bus.tw_out   <= {(inv_q ? p1_im : -p1_im), (p1_re_neg ? -p1_re : p1_re)};
      bus.tw_stage <= p1_stage;
      bus.tw_last  <= p1_last;
    end
  end
endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen (N=64): vector table, full-sequence model, stall/abort/restart sequences.
// Build with TW_INV_EN defined to also exercise conjugate twiddles.
`timescale 1ns/1ps
module tb_twiddle_gen;
  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int TOTAL = N / 2 * LOG2N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0]      b_out   [TOTAL];
  logic [LOG2N-1:0] b_stage [TOTAL];
  logic             b_last  [TOTAL];

  typedef struct {
    int          stage;
    int          b;
    logic [31:0] fwd;
    logic [31:0] inv;
  } vec_t;
  vec_t vecs [6];

  twiddle_gen_if #(.LOG2N(LOG2N)) bus ();

  twiddle_gen #(.N(N), .LOG2N(LOG2N), .ROM_FILE("cos_q15.mem")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rnd_q(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [31:0] model(input int idx, input bit inv);
    int  s, b, k, re, im;
    real th;
    s  = idx / (N / 2);
    b  = idx % (N / 2);
    k  = (b & ((1 << s) - 1)) << (LOG2N - 1 - s);
    th = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    re = rnd_q(32767.0 * $cos(th));
    im = -rnd_q(32767.0 * $sin(th));
    if (inv) im = -im;
    return {im[15:0], re[15:0]};
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out"},   bus.tw_out, 32'h0);
    check({tag, "_valid"}, {31'h0, bus.tw_valid}, 32'h0);
    check({tag, "_stage"}, {26'h0, bus.tw_stage}, 32'h0);
    check({tag, "_last"},  {31'h0, bus.tw_last}, 32'h0);
    check({tag, "_busy"},  {31'h0, bus.busy}, 32'h0);
    check({tag, "_done"},  {31'h0, bus.done}, 32'h0);
  endtask

  // pre: start already driven this cycle by the caller; chain: raise start in the done cycle
  task automatic run_seq(input bit pre, input bit rnd, input int poke, input int abort_at,
                         input bit inv_v, input bit chain);
    int               t0, first, last_acc, nb, ndone;
    bit               fin, aborted, prev_stall, rdy;
    logic [31:0]      prev_out;
    logic [LOG2N-1:0] prev_stage;
    first = -1; last_acc = -1; nb = 0; ndone = 0;
    fin = 1'b0; aborted = 1'b0; prev_stall = 1'b0;
    prev_out = '0; prev_stage = '0;
    if (!pre) begin
      repeat (2) @(posedge clk);
      #1;
`ifdef TW_INV_EN
      bus.inv = inv_v;
`endif
      bus.start = 1'b1;
    end
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
`ifdef TW_INV_EN
    bus.inv = ~inv_v;
`endif
    for (int c = 0; c < 3000 && !fin; c++) begin
      bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        fin = 1'b1;
        check("done_after_last", cyc, last_acc + 1);
        check("busy_at_done", {31'h0, bus.busy}, 32'h0);
        if (chain) bus.start = 1'b1;
      end else if (abort_at >= 0 && nb == abort_at) begin
        rst = 1'b1;
        bus.tw_ready = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("abort");
        rst = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          if (bus.done) ndone++;
        end
        check("no_done_after_abort", ndone, 0);
        aborted = 1'b1;
        fin = 1'b1;
      end else begin
        if (bus.tw_valid && first < 0) first = cyc;
        if (prev_stall) begin
          check("stall_valid", {31'h0, bus.tw_valid}, 32'h1);
          check("stall_out", bus.tw_out, prev_out);
          check("stall_stage", {26'h0, bus.tw_stage}, {26'h0, prev_stage});
        end
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.tw_ready = rdy;
        prev_stall = bus.tw_valid && !rdy;
        prev_out   = bus.tw_out;
        prev_stage = bus.tw_stage;
        if (bus.tw_valid && rdy) begin
          if (nb < TOTAL) begin
            b_out[nb]   = bus.tw_out;
            b_stage[nb] = bus.tw_stage;
            b_last[nb]  = bus.tw_last;
          end
          nb++;
          last_acc = cyc;
        end
        if (poke >= 0 && nb == poke) bus.start = 1'b1;
        @(posedge clk); #1;
      end
    end
    check("finished_in_budget", {31'h0, fin}, 32'h1);
    check("first_valid_latency", first, t0 + 3);
    if (!aborted) begin
      check("beat_count", nb, TOTAL);
      check("done_pulses", ndone, 1);
      if (!rnd) check("no_gaps", last_acc - first, TOTAL - 1);
      for (int i = 0; i < TOTAL && i < nb; i++) begin
        check("beat_value", b_out[i], model(i, inv_v));
        check("beat_stage", {26'h0, b_stage[i]}, i / (N / 2));
        check("beat_last", {31'h0, b_last[i]}, (i == TOTAL - 1) ? 32'h1 : 32'h0);
      end
    end
  endtask

  task automatic check_vecs(input bit inv_v);
    for (int i = 0; i < 6; i++)
      check(inv_v ? "vec_inv" : "vec_fwd", b_out[vecs[i].stage * (N / 2) + vecs[i].b],
            inv_v ? vecs[i].inv : vecs[i].fwd);
  endtask

  initial begin
    vecs[0] = '{0,  0, 32'h0000_7FFF, 32'h0000_7FFF};
    vecs[1] = '{1,  1, 32'h8001_0000, 32'h7FFF_0000};
    vecs[2] = '{2,  1, 32'hA57E_5A82, 32'h5A82_5A82};
    vecs[3] = '{2,  3, 32'hA57E_A57E, 32'h5A82_A57E};
    vecs[4] = '{4,  5, 32'h9593_471C, 32'h6A6D_471C};
    vecs[5] = '{5, 31, 32'hF374_809F, 32'h0C8C_809F};

    bus.start    = 1'b0;
    bus.tw_ready = 1'b1;
`ifdef TW_INV_EN
    bus.inv      = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    run_seq(1'b0, 1'b0, -1, -1, 1'b0, 1'b0);   // full run, ready held high
    check_vecs(1'b0);
    run_seq(1'b0, 1'b1, -1, -1, 1'b0, 1'b0);   // random back-pressure
    run_seq(1'b0, 1'b0, 50, -1, 1'b0, 1'b0);   // start while busy
    run_seq(1'b0, 1'b0, -1, 100, 1'b0, 1'b0);  // reset mid-sequence
    run_seq(1'b0, 1'b0, -1, -1, 1'b0, 1'b1);   // ends with start raised in the done cycle
    run_seq(1'b1, 1'b0, 0, -1, 1'b0, 1'b0);    // that start launches; next-cycle start ignored
`ifdef TW_INV_EN
    run_seq(1'b0, 1'b1, -1, -1, 1'b1, 1'b0);
    check_vecs(1'b1);
    run_seq(1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    check_vecs(1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
